// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//
// Multi-master Wishbone-classic interconnect. NUM_MASTERS masters share one
// path to NUM_SLAVES address-decoded slaves. Masters are served one at a time
// in round-robin order. Each master gets a registered one-cycle ack. Unmapped
// addresses and slaves that never ack both get an error response instead.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   mstr_stb_i/we_i               per-master strobe / write enable
//   mstr_adr_i/dat_i              packed address / write data (master 0 in LSBs)
//   mstr_ack_o/err_o/dat_o        per-master one-cycle ack, error, read data
//   bus_slv_addr_decode_value/mask  static per-slave decode value / mask
//   slv_stb_o                     strobe, asserted only to the selected slave
//   slv_we_o/adr_o/dat_o          granted master's request, copied to every slave
//   slv_ack_i/dat_i               slave ack / read data
//   busy_o                        high while a transaction is in flight
//   err_count_o                   saturating count of error responses
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
   parameter int WB_DATA_WIDTH  = 8,
   parameter int WB_ADDR_WIDTH  = 16,
   parameter int NUM_MASTERS    = 2,
   parameter int NUM_SLAVES     = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter logic [WB_DATA_WIDTH-1:0] ERR_DATA = 8'hFF
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NUM_MASTERS-1:0]              mstr_stb_i,
   input  logic [NUM_MASTERS-1:0]              mstr_we_i,
   input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] mstr_adr_i,
   input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] mstr_dat_i,
   output logic [NUM_MASTERS-1:0]              mstr_ack_o,
   output logic [NUM_MASTERS-1:0]              mstr_err_o,
   output logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] mstr_dat_o,
   input  logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]  bus_slv_addr_decode_value,
   input  logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]  bus_slv_addr_decode_mask,
   output logic [NUM_SLAVES-1:0]               slv_stb_o,
   output logic [NUM_SLAVES-1:0]               slv_we_o,
   output logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]  slv_adr_o,
   output logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  slv_dat_o,
   input  logic [NUM_SLAVES-1:0]               slv_ack_i,
   input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  slv_dat_i,
   output logic                                busy_o,
   output logic [7:0]                          err_count_o
);

   localparam int DW = WB_DATA_WIDTH;
   localparam int AW = WB_ADDR_WIDTH;
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Timer value seen in the last ACTIVE cycle before a timeout is declared.
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [MW-1:0]   grant_q, grant_d;
   logic [MW-1:0]   last_grant_q, last_grant_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            err_q, err_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      err_count_q, err_count_d;

   // Round-robin candidate index: base + off, wrapped once modulo NUM_MASTERS.
   // off never exceeds NUM_MASTERS, so one subtraction is enough.
   function automatic logic [MW-1:0] rr_index(input logic [MW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_MASTERS) begin
         sum = sum - NUM_MASTERS;
      end
      return MW'(sum);
   endfunction

   // ---------------------------------------------------------------------------
   // Arbitration and decode for the request that IDLE would accept.
   // ---------------------------------------------------------------------------
   logic            arb_valid;
   logic [MW-1:0]   arb_idx;
   logic [MW-1:0]   cand_idx;
   logic [AW-1:0]   win_adr;
   logic            dec_hit;
   logic [SW-1:0]   dec_idx;

   // NOTE: every signal driven from always_comb gets a default at the top of the
   // block, so no path through the block can leave it holding an old value and
   // infer a latch.
   always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      cand_idx  = '0;
      // Walk from the farthest candidate back to last_grant+1. Later hits
      // overwrite earlier ones, so the nearest requester after the previous
      // grant wins.
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         cand_idx = rr_index(last_grant_q, i);
         if (mstr_stb_i[cand_idx]) begin
            arb_valid = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   assign win_adr = mstr_adr_i[arb_idx*AW +: AW];

   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      // Walk from the highest index down so the lowest matching slave wins.
      for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
         if ((win_adr & bus_slv_addr_decode_mask[s*AW +: AW]) ==
             (bus_slv_addr_decode_value[s*AW +: AW] & bus_slv_addr_decode_mask[s*AW +: AW])) begin
            dec_hit = 1'b1;
            dec_idx = SW'(s);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Granted master and selected slave views.
   // ---------------------------------------------------------------------------
   logic            g_stb;
   logic            g_we;
   logic [AW-1:0]   g_adr;
   logic [DW-1:0]   g_dat;
   logic            sel_ack;
   logic [DW-1:0]   sel_dat;

   assign g_stb   = mstr_stb_i[grant_q];
   assign g_we    = mstr_we_i[grant_q];
   assign g_adr   = mstr_adr_i[grant_q*AW +: AW];
   assign g_dat   = mstr_dat_i[grant_q*DW +: DW];
   assign sel_ack = slv_ack_i[sel_q];
   assign sel_dat = slv_dat_i[sel_q*DW +: DW];

   // Slave side: the request goes to every port, but only the selected slave
   // sees stb. That stb follows the master's stb combinationally, so an
   // abandoned request stops at the slave in the same cycle.
   always_comb begin
      slv_stb_o = '0;
      slv_we_o  = '0;
      slv_adr_o = '0;
      slv_dat_o = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         slv_we_o[s]            = g_we;
         slv_adr_o[s*AW +: AW]  = g_adr;
         slv_dat_o[s*DW +: DW]  = g_dat;
      end
      if (state_q == ST_ACTIVE) begin
         slv_stb_o[sel_q] = g_stb;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state logic.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      sel_d        = sel_q;
      err_d        = err_q;
      rdata_d      = rdata_q;
      tmo_d        = tmo_q;
      err_count_d  = err_count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_d = arb_idx;
               sel_d   = dec_idx;
               tmo_d   = '0;
               if (dec_hit) begin
                  err_d   = 1'b0;
                  state_d = ST_ACTIVE;
               end else begin
                  // Unmapped address: skip the slave and answer with an error.
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end

         ST_ACTIVE: begin
            if (!g_stb) begin
               // The master abandoned the request. No response is sent, but it
               // still counts as its turn.
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end else if (sel_ack) begin
               // Checked before the timeout, so an ack in the last allowed
               // cycle still returns data.
               rdata_d = sel_dat;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         ST_RESP: begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
            if (err_q && (err_count_q != 8'hFF)) begin
               err_count_d = err_count_q + 8'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= MW'(NUM_MASTERS - 1);
         sel_q        <= '0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
         tmo_q        <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
         tmo_q        <= tmo_d;
         err_count_q  <= err_count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Master responses. These come straight from state flops, so the ack is
   // registered and only the granted master's bits are ever non-zero.
   // ---------------------------------------------------------------------------
   always_comb begin
      mstr_ack_o = '0;
      mstr_err_o = '0;
      mstr_dat_o = '0;
      if (state_q == ST_RESP) begin
         mstr_ack_o[grant_q]            = 1'b1;
         mstr_err_o[grant_q]            = err_q;
         mstr_dat_o[grant_q*DW +: DW]   = err_q ? ERR_DATA : rdata_q;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign err_count_o = err_count_q;

endmodule
